turn_scheduler: RTL and testbench

Turn sequencer that sits between the six player button/switch inputs and the game datapath. It synchronizes the raw buttons and accepts a move only from the player whose turn it is. Each accepted move is handed to the datapath over a valid/ready handshake. The datapath's verdict updates the elimination mask, and the turn advances to the next surviving player until one winner remains.

---
 rtl/turn_scheduler.sv | 141 ++++++++++++++
 tb/tb_turn_scheduler.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/turn_scheduler.sv
// turn_scheduler: synchronizes six player buttons, issues the current player's move over valid/ready, applies the verdict and rotates turns among survivors; define TURN_TIMEOUT_EN to force a zero-valued move after TIMEOUT_CYCLES idle cycles
module turn_scheduler #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  player_btn,
  input  logic [17:0] player_val,
  output logic        move_valid,
  output logic [2:0]  move_player,
  output logic [2:0]  move_value,
  input  logic        move_ready,
  input  logic        result_valid,
  input  logic        result_lose,
  output logic [5:0]  active_mask,
  output logic [2:0]  cur_player,
  output logic [3:0]  state_out,
  output logic        game_over,
  output logic [2:0]  winner
);
  typedef enum logic [2:0] {WAIT_PRESS, ISSUE, RESOLVE, ADVANCE, DONE} state_t;
  state_t      state, state_n;
  logic [5:0]  sync_q [SYNC_STAGES];
  logic [5:0]  hist, press, mask_n;
  logic [2:0]  pidx, mpidx, cur_n, move_player_n, move_value_n, loser, loser_n, winner_n;
  logic [4:0]  voff;
  logic [3:0]  state_out_n;
  logic        move_valid_n, game_over_n;
  if (SYNC_STAGES < 2 || TIMEOUT_CYCLES < 2) begin : g_bad_params
    $error("turn_scheduler: SYNC_STAGES and TIMEOUT_CYCLES must be at least 2");
  end
  assign pidx  = cur_player - 3'd1;
  assign mpidx = move_player - 3'd1;
  assign voff  = {2'b00, pidx} + {1'b0, pidx, 1'b0};
  assign press = sync_q[SYNC_STAGES-1] & ~hist;
  function automatic logic [2:0] next_player(input logic [2:0] cur, input logic [5:0] m);
    logic [2:0] r;
    logic [2:0] c;
    r = cur;
    for (int i = 5; i >= 1; i--) begin
      c = 3'((int'(cur) + i - 1) % 6);
      if (m[c]) r = c + 3'd1;
    end
    return r;
  endfunction
  function automatic logic [2:0] sole_player(input logic [5:0] m);
    logic [2:0] w;
    w = 3'd0;
    for (int i = 0; i < 6; i++) if (m[i]) w = 3'(i + 1);
    return w;
  endfunction
`ifdef TURN_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  logic [TW-1:0] timer;
  logic          expired;
  assign expired = timer == TW'(TIMEOUT_CYCLES - 1);
  // idle counter runs only while staying in WAIT_PRESS, so it restarts at zero on every entry
  always_ff @(posedge clk) begin
    if (reset) timer <= '0;
    else timer <= (state == WAIT_PRESS && state_n == WAIT_PRESS) ? timer + 1'b1 : '0;
  end
`else
  logic expired;
  assign expired = 1'b0;
`endif
  // button synchronizer chain plus one history stage for press-edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      hist <= '0;
    end else begin
      sync_q[0] <= player_btn;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      hist <= sync_q[SYNC_STAGES-1];
    end
  end
  // next-state and next-output computation; every output is registered below
  always_comb begin
    state_n       = state;
    move_valid_n  = move_valid;
    move_player_n = move_player;
    move_value_n  = move_value;
    mask_n        = active_mask;
    cur_n         = cur_player;
    loser_n       = loser;
    case (state)
      WAIT_PRESS: if (press[pidx] || expired) begin
        move_valid_n  = 1'b1;
        move_player_n = cur_player;
        move_value_n  = press[pidx] ? player_val[voff +: 3] : 3'd0;
        state_n       = ISSUE;
      end
      ISSUE: if (move_ready) begin
        move_valid_n = 1'b0;
        state_n      = RESOLVE;
      end
      RESOLVE: if (result_valid) begin
        if (result_lose) begin
          mask_n  = active_mask & ~(6'b1 << mpidx);
          loser_n = move_player;
        end
        state_n = (result_lose && $countones(mask_n) == 1) ? DONE : ADVANCE;
      end
      ADVANCE: begin
        cur_n   = next_player(cur_player, active_mask);
        state_n = WAIT_PRESS;
      end
      default: ;
    endcase
    game_over_n = state_n == DONE;
    winner_n    = game_over_n ? sole_player(mask_n) : 3'd0;
    state_out_n = game_over_n ? {1'b1, loser_n} : {1'b0, cur_n};
  end
  // state and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= WAIT_PRESS;
      move_valid  <= 1'b0;
      move_player <= 3'd0;
      move_value  <= 3'd0;
      active_mask <= 6'b111111;
      cur_player  <= 3'd1;
      loser       <= 3'd0;
      game_over   <= 1'b0;
      winner      <= 3'd0;
      state_out   <= 4'b0001;
    end else begin
      state       <= state_n;
      move_valid  <= move_valid_n;
      move_player <= move_player_n;
      move_value  <= move_value_n;
      active_mask <= mask_n;
      cur_player  <= cur_n;
      loser       <= loser_n;
      game_over   <= game_over_n;
      winner      <= winner_n;
      state_out   <= state_out_n;
    end
  end
endmodule

// File: tb/tb_turn_scheduler.sv
// tb_turn_scheduler: directed checks of turn rotation, handshake, elimination and game end
module tb_turn_scheduler;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [5:0]  player_btn = '0;
  logic [17:0] player_val = '0;
  logic        move_valid, move_ready = 1'b1;
  logic [2:0]  move_player, move_value, cur_player, winner;
  logic        result_valid = 1'b0, result_lose = 1'b0;
  logic [5:0]  active_mask;
  logic [3:0]  state_out;
  logic        game_over;
  int          tests = 0, fails = 0, hs_count = 0, hs_exp = 0, mv_cycles = 0;
  logic [2:0]  last_player = '0, last_value = '0;
  turn_scheduler #(.SYNC_STAGES(2), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset), .player_btn(player_btn), .player_val(player_val),
    .move_valid(move_valid), .move_player(move_player), .move_value(move_value),
    .move_ready(move_ready), .result_valid(result_valid), .result_lose(result_lose),
    .active_mask(active_mask), .cur_player(cur_player), .state_out(state_out),
    .game_over(game_over), .winner(winner)
  );
  always #5 clk = ~clk;
  // handshake monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (move_valid) mv_cycles++;
    if (move_valid && move_ready) begin
      hs_count++;
      last_player = move_player;
      last_value  = move_value;
    end
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic turn(input int p, input logic [2:0] v, input logic lose, input logic [2:0] nxt);
    player_val[3*(p-1) +: 3] = v;
    player_btn[p-1] = 1'b1;
    tick(5);
    player_btn[p-1] = 1'b0;
    hs_exp++;
    check("hs_count", hs_count, hs_exp);
    check("mover", {29'd0, last_player}, p);
    check("value", {29'd0, last_value}, {29'd0, v});
    result_valid = 1'b1;
    result_lose  = lose;
    tick(1);
    result_valid = 1'b0;
    result_lose  = 1'b0;
    tick(1);
    check("cur_player", {29'd0, cur_player}, {29'd0, nxt});
  endtask
  initial begin
    tick(2);
    reset = 1'b0;
    tick(1);
    check("rst_state_out", {28'd0, state_out}, 32'h1);
    check("rst_mask", {26'd0, active_mask}, 32'h3f);
    check("rst_move_valid", {31'd0, move_valid}, 32'h0);
    check("rst_winner", {29'd0, winner}, 32'h0);
    check("rst_game_over", {31'd0, game_over}, 32'h0);
    check("rst_move_player", {29'd0, move_player}, 32'h0);
    turn(1, 3'b100, 1'b0, 3'd2);
    check("pulse_width", mv_cycles, 1);
    check("state_out_p2", {28'd0, state_out}, 32'h2);
    player_btn[3] = 1'b1;
    tick(5);
    player_btn[3] = 1'b0;
    check("wrong_player_hs", hs_count, hs_exp);
    check("wrong_player_cur", {29'd0, cur_player}, 32'h2);
    check("wrong_player_valid", {31'd0, move_valid}, 32'h0);
    turn(2, 3'b011, 1'b0, 3'd3);
    move_ready = 1'b0;
    player_val[8:6] = 3'b101;
    player_btn[2] = 1'b1;
    tick(5);
    player_btn[2] = 1'b0;
    check("stall_valid", {31'd0, move_valid}, 32'h1);
    check("stall_player", {29'd0, move_player}, 32'h3);
    check("stall_value", {29'd0, move_value}, 32'h5);
    tick(10);
    check("stall_valid_held", {31'd0, move_valid}, 32'h1);
    check("stall_player_held", {29'd0, move_player}, 32'h3);
    check("stall_value_held", {29'd0, move_value}, 32'h5);
    check("stall_no_hs", hs_count, hs_exp);
    reset = 1'b1;
    tick(1);
    check("midrst_valid", {31'd0, move_valid}, 32'h0);
    check("midrst_state_out", {28'd0, state_out}, 32'h1);
    check("midrst_mask", {26'd0, active_mask}, 32'h3f);
    reset = 1'b0;
    move_ready = 1'b1;
    tick(1);
    turn(1, 3'd1, 1'b0, 3'd2);
    turn(2, 3'd2, 1'b0, 3'd3);
    turn(3, 3'd3, 1'b1, 3'd4);
    check("mask_no3", {26'd0, active_mask}, 32'h3b);
    turn(4, 3'd4, 1'b1, 3'd5);
    check("mask_no34", {26'd0, active_mask}, 32'h33);
    turn(5, 3'd5, 1'b0, 3'd6);
    turn(6, 3'd6, 1'b0, 3'd1);
    turn(1, 3'd7, 1'b0, 3'd2);
    turn(2, 3'd1, 1'b0, 3'd5);
    check("skip_state_out", {28'd0, state_out}, 32'h5);
    turn(5, 3'd2, 1'b0, 3'd6);
    turn(6, 3'd3, 1'b0, 3'd1);
    turn(1, 3'd4, 1'b1, 3'd2);
    check("mask_no134", {26'd0, active_mask}, 32'h32);
    turn(2, 3'd5, 1'b1, 3'd5);
    check("mask_56", {26'd0, active_mask}, 32'h30);
    check("not_over", {31'd0, game_over}, 32'h0);
    turn(5, 3'd6, 1'b1, 3'd5);
    check("game_over", {31'd0, game_over}, 32'h1);
    check("winner", {29'd0, winner}, 32'h6);
    check("done_state_out", {28'd0, state_out}, 32'hd);
    check("final_mask", {26'd0, active_mask}, 32'h20);
    player_btn = 6'b111111;
    result_valid = 1'b1;
    result_lose  = 1'b1;
    tick(6);
    player_btn = '0;
    result_valid = 1'b0;
    tick(2);
    check("done_no_hs", hs_count, hs_exp);
    check("done_valid", {31'd0, move_valid}, 32'h0);
    check("done_held", {28'd0, state_out}, 32'hd);
    check("done_winner", {29'd0, winner}, 32'h6);
`ifdef TURN_TIMEOUT_EN
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(14);
    check("timeout_early", hs_count, hs_exp);
    tick(3);
    hs_exp++;
    check("timeout_hs", hs_count, hs_exp);
    check("timeout_player", {29'd0, last_player}, 32'h1);
    check("timeout_value", {29'd0, last_value}, 32'h0);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
